// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lock_pkg
//  Brief    : Shared types and constants for the two-gate canal lock.
//  Revision : 1.0 - initial release
// ============================================================================
package lock_pkg;

  // Default drain/refill duration, shared by the entry and exit gates.
  localparam int FILL_CYCLES_DEFAULT = 8;

  // Exit-gate controller states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    READY = 3'd2,
    OPEN  = 3'd3,
    CLEAR = 3'd4,
    EXIT  = 3'd5,
    FILL  = 3'd6
  } exit_state_t;

endpackage
`default_nettype wire

// File: rtl/lock_exit_gate_if.sv
`default_nettype none
// ============================================================================
//  Module   : lock_exit_gate_if
//  Brief    : Signal bundle between the exit gate and its environment
//             (entry gate, operator switch, departure sensor).
//  Revision : 1.0 - initial release
// ============================================================================
interface lock_exit_gate_if #(
  parameter int FILL_CYCLES = lock_pkg::FILL_CYCLES_DEFAULT,
  parameter int LVL_W       = $clog2(FILL_CYCLES + 1)
);

  logic             occupied;
  logic             gate2_sw;
  logic             dep_li;
  logic             gate2_li;
  logic             drain_on;
  logic             fill_on;
  logic             water_level;
  logic             exited;
  logic [LVL_W-1:0] level;

  // Environment side: drives the requests, observes the gate.
  modport master (
    output occupied, gate2_sw, dep_li,
    input  gate2_li, drain_on, fill_on, water_level, exited, level
  );

  // Exit-gate side.
  modport slave (
    input  occupied, gate2_sw, dep_li,
    output gate2_li, drain_on, fill_on, water_level, exited, level
  );

endinterface
`default_nettype wire

// File: rtl/lock_level_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : lock_level_ctr
//  Brief    : Saturating up/down counter tracking chamber water height.
//             Resets to the upstream level (FILL_CYCLES).
//  Revision : 1.0 - initial release
// ============================================================================
module lock_level_ctr #(
  parameter int FILL_CYCLES = 8,
  parameter int LVL_W       = $clog2(FILL_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             dn,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] C_TOP = LVL_W'(FILL_CYCLES);
  localparam logic [LVL_W-1:0] C_ONE = LVL_W'(1);

  logic [LVL_W-1:0] r_level;

  // Step the level one unit per cycle, clamped to [0, FILL_CYCLES].
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= C_TOP;
    end else if (dn && !up && (r_level != '0)) begin
      r_level <= r_level - C_ONE;
    end else if (up && !dn && (r_level != C_TOP)) begin
      r_level <= r_level + C_ONE;
    end
  end

  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/lock_exit_gate.sv
`default_nettype none
// ============================================================================
//  Module   : lock_exit_gate
//  Brief    : Downstream gate controller. Drains the chamber for a sealed
//             boat, opens gate 2, waits for departure, pulses exited, then
//             refills the chamber to upstream level.
//  Revision : 1.0 - initial release
// ============================================================================
module lock_exit_gate
  import lock_pkg::*;
#(
  parameter int FILL_CYCLES = FILL_CYCLES_DEFAULT,
  parameter int LVL_W       = $clog2(FILL_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  lock_exit_gate_if.slave   bus
);

  localparam logic [LVL_W-1:0] C_ONE     = LVL_W'(1);
  localparam logic [LVL_W-1:0] C_TOP_M1  = LVL_W'(FILL_CYCLES - 1);

  exit_state_t      r_state;
  exit_state_t      w_next;
  logic [LVL_W-1:0] w_level;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Drain/fill exits use the level seen on the final edge,
  // so each phase lasts exactly FILL_CYCLES cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (bus.occupied)       w_next = DRAIN;
      DRAIN: if (w_level <= C_ONE)   w_next = READY;
      READY: if (bus.gate2_sw)       w_next = OPEN;
      // Gate 2 only closes once the boat has cleared it.
      OPEN:  if (bus.dep_li)         w_next = bus.gate2_sw ? CLEAR : EXIT;
      CLEAR: if (!bus.gate2_sw)      w_next = EXIT;
      EXIT:                          w_next = FILL;
      FILL:  if (w_level >= C_TOP_M1) w_next = IDLE;
      default:                       w_next = IDLE;
    endcase
  end

  lock_level_ctr #(
    .FILL_CYCLES (FILL_CYCLES),
    .LVL_W       (LVL_W)
  ) u_level_ctr (
    .clk   (clk),
    .reset (reset),
    .up    (r_state == FILL),
    .dn    (r_state == DRAIN),
    .level (w_level)
  );

  // Moore output decode.
  assign bus.water_level = (r_state == IDLE);
  assign bus.drain_on    = (r_state == DRAIN);
  assign bus.fill_on     = (r_state == FILL);
  assign bus.gate2_li    = (r_state == OPEN) || (r_state == CLEAR);
  assign bus.exited      = (r_state == EXIT);
  assign bus.level       = w_level;

endmodule
`default_nettype wire

// File: tb/tb_lock_exit_gate.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lock_exit_gate
//  Brief    : Self-checking bench for lock_exit_gate (FILL_CYCLES = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lock_exit_gate;

  localparam int FC = 4;
  localparam int LW = $clog2(FC + 1);

  // Reference-model phases of one boat passage.
  localparam int P_WAIT_BOAT = 0;
  localparam int P_LOWERING  = 1;
  localparam int P_AT_BOTTOM = 2;
  localparam int P_GATE_OPEN = 3;
  localparam int P_GATE_HOLD = 4;
  localparam int P_RELEASED  = 5;
  localparam int P_RAISING   = 6;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lock_exit_gate_if #(.FILL_CYCLES(FC)) bus ();

  lock_exit_gate #(.FILL_CYCLES(FC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  int m_phase;
  int m_height;
  int exit_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge(input bit rst, input bit occ, input bit sw, input bit dep);
    if (rst) begin
      m_phase  = P_WAIT_BOAT;
      m_height = FC;
    end else begin
      case (m_phase)
        P_WAIT_BOAT: if (occ) m_phase = P_LOWERING;
        P_LOWERING: begin
          m_height = m_height - 1;
          if (m_height == 0) m_phase = P_AT_BOTTOM;
        end
        P_AT_BOTTOM: if (sw) m_phase = P_GATE_OPEN;
        P_GATE_OPEN: if (dep) m_phase = sw ? P_GATE_HOLD : P_RELEASED;
        P_GATE_HOLD: if (!sw) m_phase = P_RELEASED;
        P_RELEASED:  m_phase = P_RAISING;
        default: begin
          m_height = m_height + 1;
          if (m_height == FC) m_phase = P_WAIT_BOAT;
        end
      endcase
    end
  endtask

  function automatic logic [31:0] model_out();
    logic [31:0] v;
    v = {22'd0,
         1'b0, 1'b0,
         (m_phase == P_GATE_OPEN || m_phase == P_GATE_HOLD),
         (m_phase == P_LOWERING),
         (m_phase == P_RAISING),
         (m_phase == P_WAIT_BOAT),
         (m_phase == P_RELEASED),
         3'(m_height)};
    return v;
  endfunction

  function automatic logic [31:0] dut_out();
    logic [31:0] v;
    v = {22'd0, 1'b0, 1'b0, bus.gate2_li, bus.drain_on, bus.fill_on,
         bus.water_level, bus.exited, 3'(bus.level)};
    return v;
  endfunction

  // One clock: update the model at the edge, then compare all outputs.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(reset, bus.occupied, bus.gate2_sw, bus.dep_li);
    #1;
    check(tag, dut_out(), model_out());
    if (bus.exited === 1'b1) exit_pulses++;
  endtask

  // Bring a boat from IDLE down to an open gate 2.
  task automatic run_to_open();
    bus.occupied = 1'b1;
    step("admit");
    bus.occupied = 1'b0;
    repeat (FC) step("drain");
    bus.gate2_sw = 1'b1;
    step("open");
  endtask

  // Entry-gate model for the integration run.
  bit ent_holding;
  int boats_in;
  int boats_out;
  int prev_phase;

  initial begin
    reset        = 1'b1;
    bus.occupied = 1'b0;
    bus.gate2_sw = 1'b0;
    bus.dep_li   = 1'b0;
    m_phase      = P_WAIT_BOAT;
    m_height     = FC;
    exit_pulses  = 0;

    // Reset held for two cycles.
    step("reset");
    step("reset");
    check("rst_level", 32'(bus.level), 32'(FC));
    check("rst_water", 32'(bus.water_level), 32'd1);
    reset = 1'b0;

    // Full passage.
    run_to_open();
    check("open_li", 32'(bus.gate2_li), 32'd1);
    check("bottom_level", 32'(bus.level), 32'd0);
    bus.dep_li = 1'b1;
    step("clear");
    bus.dep_li   = 1'b0;
    bus.gate2_sw = 1'b0;
    step("exit");
    check("exit_pulse", 32'(bus.exited), 32'd1);
    repeat (FC) step("fill");
    step("refilled");
    check("refill_water", 32'(bus.water_level), 32'd1);
    check("one_pulse", 32'(exit_pulses), 32'd1);

    // Departure and switch release on the same edge.
    run_to_open();
    bus.dep_li   = 1'b1;
    bus.gate2_sw = 1'b0;
    step("simul");
    check("simul_exit", 32'(bus.exited), 32'd1);
    bus.dep_li = 1'b0;
    repeat (FC + 1) step("simul_fill");

    // Switch released early: gate stays open until departure.
    run_to_open();
    bus.gate2_sw = 1'b0;
    repeat (2) step("early_rel");
    check("early_hold", 32'(bus.gate2_li), 32'd1);
    bus.gate2_sw = 1'b1;
    bus.dep_li   = 1'b1;
    step("hold_clear");
    bus.dep_li = 1'b0;
    repeat (2) step("hold_clear");
    check("clear_hold", 32'(bus.gate2_li), 32'd1);
    bus.gate2_sw = 1'b0;
    step("hold_exit");
    repeat (FC + 1) step("hold_fill");

    // Reset mid-drain at level 2.
    bus.occupied = 1'b1;
    step("mid_admit");
    bus.occupied = 1'b0;
    repeat (2) step("mid_drain");
    check("mid_level", 32'(bus.level), 32'd2);
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    check("mid_drain_off", 32'(bus.drain_on), 32'd0);
    check("mid_level_rst", 32'(bus.level), 32'(FC));

    // Random input traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      bus.occupied = 1'($urandom_range(0, 1));
      bus.gate2_sw = 1'($urandom_range(0, 1));
      bus.dep_li   = 1'($urandom_range(0, 1));
      reset        = ($urandom_range(0, 49) == 0);
      step("random");
    end
    reset = 1'b1;
    bus.occupied = 1'b0;
    step("int_reset");
    reset = 1'b0;

    // Integration with an entry gate: admit only at upstream level,
    // release the boat on the exited pulse.
    ent_holding = 1'b0;
    boats_in    = 0;
    boats_out   = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ent_holding && bus.water_level === 1'b1 && $urandom_range(0, 2) == 0) begin
        ent_holding = 1'b1;
        boats_in++;
      end else if (ent_holding && bus.exited === 1'b1) begin
        ent_holding = 1'b0;
        boats_out++;
      end else if (bus.exited === 1'b1) begin
        check("exit_no_boat", 32'd1, 32'd0);
      end
      bus.occupied = ent_holding;
      bus.gate2_sw = ($urandom_range(0, 3) != 0);
      bus.dep_li   = 1'($urandom_range(0, 1));
      prev_phase   = m_phase;
      step("integ");
      if (m_phase == P_WAIT_BOAT && prev_phase == P_RAISING)
        check("reentry_occ", 32'(bus.occupied), 32'd0);
    end
    check("boats_balance", 32'(boats_in - boats_out <= 1 && boats_out > 2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
